// File: rtl/mem_test_axi_responder.sv
// AXI4 INCR-burst subordinate backed by an internal word array.
// It serves one write and one read burst at a time, and it can flip bit 0 of read data for error injection.
module mem_test_axi_responder #(
  parameter int unsigned AXI_ADDR_WIDTH = 20,
  parameter int unsigned AXI_DATA_WIDTH = 16,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned MEM_ADDR_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]                  s_axi_awlen,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wlast,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                  s_axi_bresp,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]                  s_axi_arlen,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rlast,
  input  logic                        err_inject
);

  localparam int unsigned STRB_W  = AXI_DATA_WIDTH / 8;
  localparam int unsigned BYTE_SH = $clog2(STRB_W);
  localparam int unsigned DEPTH   = 2 ** MEM_ADDR_WIDTH;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [AXI_DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write channel state
  logic [1:0]                w_state_q, w_state_d;
  logic [MEM_ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]                w_cnt_q, w_cnt_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [AXI_ID_WIDTH-1:0]   bid_q, bid_d;
  logic                      mem_we_c;

  // Read channel state
  logic [0:0]                r_state_q, r_state_d;
  logic [MEM_ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]                r_cnt_q, r_cnt_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      rlast_q, rlast_d;
  logic [AXI_ID_WIDTH-1:0]   rid_q, rid_d;
  logic [MEM_ADDR_WIDTH-1:0] rd_idx_c;
  logic [AXI_DATA_WIDTH-1:0] rd_word_c;

  // Only the word-index bits of the byte addresses select array entries
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = RESP_OKAY;

  // Write FSM next-state and outputs
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_cnt_d   = w_cnt_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    mem_we_c  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          w_addr_d  = s_axi_awaddr[BYTE_SH +: MEM_ADDR_WIDTH];
          w_cnt_d   = s_axi_awlen;
          bid_d     = s_axi_awid;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          mem_we_c = 1'b1;
          w_addr_d = w_addr_q + MEM_ADDR_WIDTH'(1);
          w_cnt_d  = w_cnt_q - 8'd1;
          // Either the beat count or wlast closes the burst; disagreement is a protocol error
          if ((w_cnt_q == 8'd0) || s_axi_wlast) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = ((w_cnt_q == 8'd0) == s_axi_wlast) ? RESP_OKAY : RESP_SLVERR;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        w_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_cnt_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_cnt_q   <= w_cnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
    end
  end

  // Byte-lane write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (s_axi_wstrb[b]) begin
          mem_q[w_addr_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read FSM: rdata is captured one cycle ahead so a beat can retire every cycle
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_cnt_d   = r_cnt_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rd_idx_c  = r_addr_q;
    if (r_state_q == R_IDLE) begin
      rd_idx_c = s_axi_araddr[BYTE_SH +: MEM_ADDR_WIDTH];
    end
    rd_word_c = mem_q[rd_idx_c] ^ AXI_DATA_WIDTH'(err_inject);
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_word_c;
          rlast_d   = (s_axi_arlen == 8'd0);
          rid_d     = s_axi_arid;
          r_addr_d  = rd_idx_c + MEM_ADDR_WIDTH'(1);
          r_cnt_d   = s_axi_arlen;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && s_axi_rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            rdata_d  = rd_word_c;
            rlast_d  = (r_cnt_q == 8'd1);
            r_addr_d = r_addr_q + MEM_ADDR_WIDTH'(1);
            r_cnt_d  = r_cnt_q - 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_cnt_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_cnt_q   <= r_cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
    end
  end

endmodule
